// File: rtl/addr_map_cfg_pkg.sv
// -----------------------------------------------------------------------------
// addr_map_cfg_pkg
//
// Shared types for the address-map configuration controller:
//   cfg_op_e       - request opcode carried on cfg_op_i
//   state_e        - controller FSM state (also exported for debug)
//   default_addr_t - address type used when the integrator does not supply one
//   default_rule_t - rule layout used when the integrator does not supply one
//   idx_width()    - width needed to index n items (never below 1)
// -----------------------------------------------------------------------------
package addr_map_cfg_pkg;

  typedef enum logic [1:0] {
    OP_WRITE   = 2'd0,
    OP_COMMIT  = 2'd1,
    OP_DISCARD = 2'd2,
    OP_RSVD    = 2'd3
  } cfg_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  typedef logic [31:0] default_addr_t;

  typedef struct packed {
    logic [31:0]   idx;
    default_addr_t start_addr;
    default_addr_t end_addr;
  } default_rule_t;

  // Number of bits needed to address n entries; a single entry still gets a
  // one-bit index so that ports never collapse to zero width.
  function automatic int unsigned idx_width(input int unsigned n);
    if (n > 32'd1) begin
      return unsigned'($clog2(n));
    end
    return 32'd1;
  endfunction

endpackage

// File: rtl/addr_rule_check.sv
// -----------------------------------------------------------------------------
// addr_rule_check
//
// Purely combinational legality check for one rule headed for one shadow slot.
// A rule is accepted when all of the following hold:
//   - the slot exists (slot < NoRules)
//   - the rule index is in range (idx < NoIndices)
//   - for start/end rules, an end address of zero means "open ended";
//     otherwise start must lie strictly below end. NAPOT rules skip this.
//
// Ports:
//   slot_i  in  RuleIdxWidth  target shadow slot
//   rule_i  in  rule_t        candidate rule
//   ok_o    out 1             rule may be written
// -----------------------------------------------------------------------------
module addr_rule_check
  import addr_map_cfg_pkg::*;
#(
  parameter int unsigned NoIndices    = 32'd0,
  parameter int unsigned NoRules      = 32'd0,
  parameter type         addr_t       = default_addr_t,
  parameter type         rule_t       = default_rule_t,
  parameter bit          Napot        = 1'b0,
  parameter int unsigned RuleIdxWidth = idx_width(NoRules)
) (
  input  logic [RuleIdxWidth-1:0] slot_i,
  input  rule_t                   rule_i,
  output logic                    ok_o
);

  logic slot_ok;
  logic idx_ok;
  logic range_ok;

  always_comb begin
    slot_ok  = 32'(slot_i) < NoRules;
    // Rule indices are compared as 32-bit values, matching NoIndices.
    idx_ok   = 32'(rule_i.idx) < NoIndices;
    range_ok = Napot
            || (rule_i.end_addr == addr_t'(0))
            || (rule_i.start_addr < rule_i.end_addr);
    ok_o     = slot_ok && idx_ok && range_ok;
  end

endmodule

// File: rtl/addr_map_cfg_ctrl.sv
// -----------------------------------------------------------------------------
// addr_map_cfg_ctrl
//
// Run-time configuration controller for a dynamic address decoder. Software
// edits a shadow rule table one slot at a time; a COMMIT quiesces downstream
// traffic and copies the whole shadow table into the active table in a single
// cycle while config_ongoing_o is high, so the decoder never sees a partially
// updated map.
//
// Request handshake: a request transfers on a rising edge where
// cfg_valid_i && cfg_ready_o. The requester holds cfg_op_i/cfg_slot_i/
// cfg_rule_i stable while cfg_valid_i is high and not yet accepted. Every
// accepted request produces exactly one single-cycle cfg_rsp_valid_o pulse;
// responses cannot be back-pressured.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   cfg_valid_i         request valid
//   cfg_ready_o         request ready (IDLE and out of reset only)
//   cfg_op_i            WRITE / COMMIT / DISCARD / reserved
//   cfg_slot_i          shadow slot for WRITE
//   cfg_rule_i          rule for WRITE
//   cfg_rsp_valid_o     response pulse
//   cfg_rsp_err_o       response error flag (qualified by cfg_rsp_valid_o)
//   quiesce_req_o       downstream must stop issuing and drain
//   quiesce_ack_i       downstream is idle
//   addr_map_o          active rule table for the decoder(s)
//   config_ongoing_o    active table is being replaced this cycle
//   dirty_o             shadow holds uncommitted writes
//   dbg_state_o         current FSM state, for observation only
// -----------------------------------------------------------------------------
module addr_map_cfg_ctrl
  import addr_map_cfg_pkg::*;
#(
  parameter int unsigned          NoIndices    = 32'd0,
  parameter int unsigned          NoRules      = 32'd0,
  parameter type                  addr_t       = default_addr_t,
  parameter type                  rule_t       = default_rule_t,
  parameter bit                   Napot        = 1'b0,
  parameter rule_t [NoRules-1:0]  DefaultMap   = '0,
  parameter int unsigned          DrainTimeout = 32'd0,
  parameter int unsigned          RuleIdxWidth = idx_width(NoRules)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,

  input  logic                    cfg_valid_i,
  output logic                    cfg_ready_o,
  input  logic [1:0]              cfg_op_i,
  input  logic [RuleIdxWidth-1:0] cfg_slot_i,
  input  rule_t                   cfg_rule_i,
  output logic                    cfg_rsp_valid_o,
  output logic                    cfg_rsp_err_o,

  output logic                    quiesce_req_o,
  input  logic                    quiesce_ack_i,

  output rule_t [NoRules-1:0]     addr_map_o,
  output logic                    config_ongoing_o,
  output logic                    dirty_o,

  output state_e                  dbg_state_o
);

  localparam int unsigned CntW = idx_width(DrainTimeout + 32'd1);

  // Value of the drain counter in the last cycle we are willing to wait.
  localparam logic [CntW-1:0] TmoLast = CntW'(DrainTimeout - 32'd1);

  state_e              state_q;
  rule_t [NoRules-1:0] shadow_q;
  rule_t [NoRules-1:0] active_q;
  logic                dirty_q;
  logic                rsp_valid_q;
  logic                rsp_err_q;
  logic                quiesce_q;
  logic                ongoing_q;
  logic [CntW-1:0]     drain_cnt_q;

  logic                req_fire;
  cfg_op_e             req_op;
  logic                rule_ok;
  logic                drain_tmo;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  assign cfg_ready_o = (state_q == ST_IDLE) && !rst_i;
  assign req_fire    = cfg_valid_i && cfg_ready_o;
  assign req_op      = cfg_op_e'(cfg_op_i);

  addr_rule_check #(
    .NoIndices    (NoIndices),
    .NoRules      (NoRules),
    .addr_t       (addr_t),
    .rule_t       (rule_t),
    .Napot        (Napot),
    .RuleIdxWidth (RuleIdxWidth)
  ) i_rule_check (
    .slot_i (cfg_slot_i),
    .rule_i (cfg_rule_i),
    .ok_o   (rule_ok)
  );

  // A zero DrainTimeout disables the timeout entirely.
  assign drain_tmo = (DrainTimeout != 32'd0) && (drain_cnt_q == TmoLast);

  // ---------------------------------------------------------------------------
  // Controller FSM, tables and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      shadow_q    <= DefaultMap;
      active_q    <= DefaultMap;
      dirty_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      quiesce_q   <= 1'b0;
      ongoing_q   <= 1'b0;
      drain_cnt_q <= '0;
    end else begin
      // Responses are single-cycle pulses unless re-armed below.
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;

      unique case (state_q)
        ST_IDLE: begin
          if (req_fire) begin
            unique case (req_op)
              OP_WRITE: begin
                rsp_valid_q <= 1'b1;
                if (rule_ok) begin
                  shadow_q[cfg_slot_i] <= cfg_rule_i;
                  dirty_q              <= 1'b1;
                end else begin
                  rsp_err_q <= 1'b1;
                end
              end
              OP_DISCARD: begin
                shadow_q    <= active_q;
                dirty_q     <= 1'b0;
                rsp_valid_q <= 1'b1;
              end
              OP_COMMIT: begin
                if (dirty_q) begin
                  // Response is deferred until the copy completes or the
                  // drain gives up.
                  state_q     <= ST_DRAIN;
                  quiesce_q   <= 1'b1;
                  drain_cnt_q <= '0;
                end else begin
                  rsp_valid_q <= 1'b1;
                end
              end
              OP_RSVD: begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= 1'b1;
              end
              default: ;
            endcase
          end
        end

        ST_DRAIN: begin
          if (drain_cnt_q != {CntW{1'b1}}) begin
            drain_cnt_q <= drain_cnt_q + CntW'(1);
          end
          // An acknowledge in the final waiting cycle still commits.
          if (quiesce_ack_i) begin
            state_q   <= ST_COMMIT;
            ongoing_q <= 1'b1;
          end else if (drain_tmo) begin
            // Shadow and dirty are kept so software can simply retry.
            state_q     <= ST_IDLE;
            quiesce_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
          end
        end

        ST_COMMIT: begin
          active_q    <= shadow_q;
          dirty_q     <= 1'b0;
          state_q     <= ST_IDLE;
          ongoing_q   <= 1'b0;
          quiesce_q   <= 1'b0;
          rsp_valid_q <= 1'b1;
        end

        default: begin
          state_q   <= ST_IDLE;
          quiesce_q <= 1'b0;
          ongoing_q <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all straight from registers, so the decoder sees no glitches.
  // ---------------------------------------------------------------------------
  assign addr_map_o       = active_q;
  assign config_ongoing_o = ongoing_q;
  assign quiesce_req_o    = quiesce_q;
  assign dirty_o          = dirty_q;
  assign cfg_rsp_valid_o  = rsp_valid_q;
  assign cfg_rsp_err_o    = rsp_err_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_addr_map_cfg_ctrl.sv
module tb_addr_map_cfg_ctrl;
  import addr_map_cfg_pkg::*;

  localparam int unsigned NO_IDX   = 4;
  localparam int unsigned NO_RULES = 6;
  localparam int unsigned TMO      = 8;

  typedef logic [31:0] tb_addr_t;
  typedef struct packed {
    logic [7:0] idx;
    tb_addr_t   start_addr;
    tb_addr_t   end_addr;
  } tb_rule_t;
  typedef tb_rule_t [NO_RULES-1:0] tb_map_t;

  function automatic tb_map_t make_def();
    tb_map_t m;
    for (int i = 0; i < NO_RULES; i++) begin
      m[i].idx        = 8'(i % 4);
      m[i].start_addr = 32'(i * 32'h100);
      m[i].end_addr   = 32'(i * 32'h100 + 32'h80);
    end
    return m;
  endfunction

  localparam tb_map_t DEF_MAP = make_def();

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [1:0] cfg_op = 2'd0;
  logic [2:0] cfg_slot = 3'd0;
  tb_rule_t   cfg_rule = '0;
  logic       cfg_rsp_valid;
  logic       cfg_rsp_err;
  logic       quiesce_req;
  logic       quiesce_ack = 1'b1;
  tb_map_t    addr_map;
  logic       config_ongoing;
  logic       dirty;
  state_e     dbg_state;

  always #5 clk = ~clk;

  addr_map_cfg_ctrl #(
    .NoIndices    (NO_IDX),
    .NoRules      (NO_RULES),
    .addr_t       (tb_addr_t),
    .rule_t       (tb_rule_t),
    .Napot        (1'b0),
    .DefaultMap   (DEF_MAP),
    .DrainTimeout (TMO)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .cfg_valid_i      (cfg_valid),
    .cfg_ready_o      (cfg_ready),
    .cfg_op_i         (cfg_op),
    .cfg_slot_i       (cfg_slot),
    .cfg_rule_i       (cfg_rule),
    .cfg_rsp_valid_o  (cfg_rsp_valid),
    .cfg_rsp_err_o    (cfg_rsp_err),
    .quiesce_req_o    (quiesce_req),
    .quiesce_ack_i    (quiesce_ack),
    .addr_map_o       (addr_map),
    .config_ongoing_o (config_ongoing),
    .dirty_o          (dirty),
    .dbg_state_o      (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [0:0] exp_q[$];

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every response pulse is matched in order against the expected error flag.
  always @(negedge clk) begin
    if (cfg_rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $error("FAIL rsp_unexpected: observed err %0b expected no response", cfg_rsp_err);
      end else begin
        chk("rsp_err", 512'(cfg_rsp_err), 512'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver ----------------
  // Called #1 after a rising edge; the request is accepted on the next edge.
  task automatic do_req(input logic [1:0] op, input logic [2:0] slot, input tb_rule_t rule,
                        input logic exp_err, output logic rsp_seen);
    cfg_valid = 1'b1;
    cfg_op    = op;
    cfg_slot  = slot;
    cfg_rule  = rule;
    exp_q.push_back(exp_err);
    @(negedge clk);
    rsp_seen = cfg_rsp_valid;
    chk("ready", 512'(cfg_ready), 512'(1));
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
  endtask

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    tb_map_t  exp_map;
    tb_rule_t r1, r2, r3, r4, rb, bad_idx, bad_rng;
    tb_rule_t r6[4];
    logic     s;
    logic     seen[5];

    r1      = '{idx: 8'd1, start_addr: 32'h1000, end_addr: 32'h2000};
    r2      = '{idx: 8'd2, start_addr: 32'h4000, end_addr: 32'h5000};
    r3      = '{idx: 8'd0, start_addr: 32'h6000, end_addr: 32'h6100};
    r4      = '{idx: 8'd1, start_addr: 32'h7000, end_addr: 32'h7100};
    rb      = '{idx: 8'(NO_IDX - 1), start_addr: 32'h5000, end_addr: 32'h0};
    bad_idx = '{idx: 8'(NO_IDX), start_addr: 32'h1000, end_addr: 32'h2000};
    bad_rng = '{idx: 8'd1, start_addr: 32'h3000, end_addr: 32'h2000};
    for (int i = 0; i < 4; i++) begin
      r6[i] = '{idx: 8'(i), start_addr: 32'(32'h8000 + i * 16), end_addr: 32'(32'h8008 + i * 16)};
    end
    exp_map = DEF_MAP;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 512'(cfg_ready), 512'(0));
    chk("rst_rsp", 512'(cfg_rsp_valid), 512'(0));
    chk("rst_quiesce", 512'(quiesce_req), 512'(0));
    chk("rst_ongoing", 512'(config_ongoing), 512'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_map", 512'(addr_map), 512'(DEF_MAP));
    chk("rst_dirty", 512'(dirty), 512'(0));
    chk("rst_state", 512'(dbg_state), 512'(ST_IDLE));
    to_drive();

    // WRITE, DISCARD, COMMIT: no drain, map untouched
    do_req(2'd0, 3'd0, r1, 1'b0, s);
    @(negedge clk); chk("wd_dirty_set", 512'(dirty), 512'(1));
    to_drive();
    do_req(2'd2, 3'd0, '0, 1'b0, s);
    @(negedge clk);
    chk("wd_dirty_clr", 512'(dirty), 512'(0));
    chk("wd_quiesce", 512'(quiesce_req), 512'(0));
    to_drive();
    do_req(2'd1, 3'd0, '0, 1'b0, s);
    @(negedge clk);
    chk("clean_commit_rsp", 512'(cfg_rsp_valid), 512'(1));
    chk("clean_commit_quiesce", 512'(quiesce_req), 512'(0));
    chk("clean_commit_map", 512'(addr_map), 512'(DEF_MAP));
    to_drive();

    // WRITE then COMMIT with ack held high: 3 cycles to response
    do_req(2'd0, 3'd0, r1, 1'b0, s);
    to_drive();
    do_req(2'd1, 3'd0, '0, 1'b0, s);
    @(negedge clk);
    chk("c1_quiesce", 512'(quiesce_req), 512'(1));
    chk("c1_ongoing", 512'(config_ongoing), 512'(0));
    chk("c1_rsp", 512'(cfg_rsp_valid), 512'(0));
    @(negedge clk);
    chk("c2_ongoing", 512'(config_ongoing), 512'(1));
    chk("c2_quiesce", 512'(quiesce_req), 512'(1));
    chk("c2_map_old", 512'(addr_map), 512'(exp_map));
    @(negedge clk);
    exp_map[0] = r1;
    chk("c3_rsp", 512'(cfg_rsp_valid), 512'(1));
    chk("c3_ongoing", 512'(config_ongoing), 512'(0));
    chk("c3_quiesce", 512'(quiesce_req), 512'(0));
    chk("c3_map", 512'(addr_map), 512'(exp_map));
    chk("c3_dirty", 512'(dirty), 512'(0));
    to_drive();

    // Illegal writes, back to back; then a legal open-ended rule at idx max
    do_req(2'd0, 3'd0, bad_idx, 1'b1, s);
    do_req(2'd0, 3'd1, bad_rng, 1'b1, s);
    do_req(2'd0, 3'(NO_RULES), r2, 1'b1, s);
    do_req(2'd3, 3'd0, '0, 1'b1, s);
    @(negedge clk); chk("bad_dirty", 512'(dirty), 512'(0));
    to_drive();
    do_req(2'd0, 3'd1, rb, 1'b0, s);
    @(negedge clk); chk("open_end_dirty", 512'(dirty), 512'(1));
    to_drive();

    // Drain timeout with ack held low
    quiesce_ack = 1'b0;
    do_req(2'd0, 3'd2, r2, 1'b0, s);
    do_req(2'd1, 3'd0, '0, 1'b1, s);
    for (int k = 1; k <= int'(TMO); k++) begin
      @(negedge clk);
      chk("tmo_wait_rsp", 512'(cfg_rsp_valid), 512'(0));
      chk("tmo_wait_quiesce", 512'(quiesce_req), 512'(1));
    end
    @(negedge clk);
    chk("tmo_rsp", 512'(cfg_rsp_valid), 512'(1));
    chk("tmo_quiesce_drop", 512'(quiesce_req), 512'(0));
    chk("tmo_map", 512'(addr_map), 512'(exp_map));
    chk("tmo_dirty", 512'(dirty), 512'(1));
    to_drive();

    // Retry with ack
    quiesce_ack = 1'b1;
    do_req(2'd1, 3'd0, '0, 1'b0, s);
    repeat (3) @(negedge clk);
    exp_map[1] = rb;
    exp_map[2] = r2;
    chk("retry_map", 512'(addr_map), 512'(exp_map));
    to_drive();

    // Ack arrives in the last cycle before timeout: commit wins
    quiesce_ack = 1'b0;
    do_req(2'd0, 3'd3, r3, 1'b0, s);
    do_req(2'd1, 3'd0, '0, 1'b0, s);
    repeat (int'(TMO) - 1) @(posedge clk);
    #1 quiesce_ack = 1'b1;
    @(negedge clk);
    chk("tie_c8_ongoing", 512'(config_ongoing), 512'(0));
    chk("tie_c8_rsp", 512'(cfg_rsp_valid), 512'(0));
    @(negedge clk);
    chk("tie_c9_ongoing", 512'(config_ongoing), 512'(1));
    @(negedge clk);
    exp_map[3] = r3;
    chk("tie_rsp", 512'(cfg_rsp_valid), 512'(1));
    chk("tie_map", 512'(addr_map), 512'(exp_map));
    to_drive();

    // Reset during the COMMIT cycle
    do_req(2'd0, 3'd4, r4, 1'b0, s);
    do_req(2'd1, 3'd0, '0, 1'b0, s);
    to_drive();
    chk("rc_in_commit", 512'(config_ongoing), 512'(1));
    rst = 1'b1;
    to_drive();
    rst = 1'b0;
    exp_q.delete();
    exp_map = DEF_MAP;
    @(negedge clk);
    chk("rc_map", 512'(addr_map), 512'(DEF_MAP));
    chk("rc_rsp", 512'(cfg_rsp_valid), 512'(0));
    chk("rc_ongoing", 512'(config_ongoing), 512'(0));
    chk("rc_quiesce", 512'(quiesce_req), 512'(0));
    chk("rc_dirty", 512'(dirty), 512'(0));
    to_drive();

    // Four back-to-back writes
    for (int i = 0; i < 4; i++) begin
      do_req(2'd0, 3'(i), r6[i], 1'b0, seen[i]);
    end
    @(negedge clk);
    seen[4] = cfg_rsp_valid;
    chk("b2b_first_none", 512'(seen[0]), 512'(0));
    for (int i = 1; i < 5; i++) begin
      chk("b2b_rsp_pulse", 512'(seen[i]), 512'(1));
    end
    to_drive();
    do_req(2'd1, 3'd0, '0, 1'b0, s);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) exp_map[i] = r6[i];
    chk("b2b_map", 512'(addr_map), 512'(exp_map));

    repeat (3) @(negedge clk);
    chk("queue_empty", 512'(exp_q.size()), 512'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/addr_map_cfg_ctrl.md
Name: addr_map_cfg_ctrl

Overview:
- Run-time configuration controller for the dynamic-configuration address decoder.
- Holds a shadow rule table that software writes rule by rule through a valid/ready port, and rejects invalid rules at write time.
- On commit, quiesces downstream traffic and atomically copies the shadow table into the active table while asserting config-ongoing.
- Sits between a register interface and one or more decoder instances: drives their address map and config-ongoing inputs.

Parameters:
- NoIndices, 32'd0: highest legal rule index (exclusive); must be > 0.
- NoRules, 32'd0: number of rule slots; must be > 0.
- addr_t, logic: address type.
- rule_t, logic: packed rule struct with fields idx, start_addr, end_addr.
- Napot, 1'b0: rules are base/mask (NAPOT) rather than start/end ranges.
- DefaultMap, '0: rule_t [NoRules-1:0] reset value of the shadow and active tables.
- DrainTimeout, 32'd0: maximum cycles to wait for quiesce acknowledge; 0 = wait forever.
- RuleIdxWidth, cf_math_pkg::idx_width(NoRules): dependent, do not override.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- cfg_valid_i  in  1  configuration request valid.
- cfg_ready_o  out  1  request accepted when valid && ready.
- cfg_op_i  in  2  operation: 0 WRITE, 1 COMMIT, 2 DISCARD, 3 reserved.
- cfg_slot_i  in  RuleIdxWidth  shadow slot to write (WRITE only).
- cfg_rule_i  in  rule_t  rule to write (WRITE only).
- cfg_rsp_valid_o  out  1  single-cycle response pulse.
- cfg_rsp_err_o  out  1  response error flag; valid only with cfg_rsp_valid_o.
- quiesce_req_o  out  1  asks downstream to stop issuing and drain.
- quiesce_ack_i  in  1  downstream is idle.
- addr_map_o  out  rule_t[NoRules]  active map, to the decoder.
- config_ongoing_o  out  1  to the decoder's config-ongoing input.
- dirty_o  out  1  shadow table differs from active (uncommitted writes exist).

Behaviour:
- Reset state: FSM in IDLE; shadow = active = DefaultMap; dirty_o = 0; drain counter = 0.
- Output values during reset: cfg_ready_o = 0, cfg_rsp_valid_o = 0, cfg_rsp_err_o = 0, quiesce_req_o = 0, config_ongoing_o = 0.
- Reset mid-drain or mid-commit: takes effect on the next edge. Discards the shadow table and restores DefaultMap in both tables; no response is emitted.
- FSM states: IDLE, DRAIN, COMMIT. cfg_ready_o = 1 only in IDLE and not in reset.
- IDLE, WRITE accepted at cycle t: rule_check runs combinationally. Response at t+1.
  - Pass: shadow[slot] <= rule at the t edge; dirty <= 1; error = 0.
  - Fail (slot >= NoRules; idx >= NoIndices; or !Napot && end != 0 && start >= end): shadow unchanged; error = 1.
  - Back-to-back writes are allowed, one per cycle.
- IDLE, DISCARD: shadow <= active; dirty <= 0; response at t+1 with error = 0.
- IDLE, op 3: no state change; response at t+1 with error = 1.
- IDLE, COMMIT with dirty = 0: response at t+1 with error = 0; no drain.
- IDLE, COMMIT with dirty = 1: go to DRAIN at t+1.
- DRAIN:
  - quiesce_req_o = 1; the counter increments each cycle.
  - quiesce_ack_i = 1 in cycle d: go to COMMIT at d+1.
  - DrainTimeout != 0 and counter reaches DrainTimeout-1 without ack: go to IDLE, response with error = 1, quiesce_req_o drops. Shadow and dirty are retained.
  - Ack and timeout in the same cycle: ack wins.
- COMMIT (exactly one cycle):
  - config_ongoing_o = 1; quiesce_req_o = 1.
  - active <= shadow on the closing edge; dirty <= 0.
  - Next cycle: IDLE, new map on addr_map_o, config_ongoing_o = 0, quiesce_req_o = 0, response with error = 0.
- Response timing: cfg_rsp_valid_o is asserted for one cycle per accepted request. No backpressure on responses.
- Output timing: addr_map_o is driven directly from the active register and only changes on the COMMIT edge or on reset. config_ongoing_o is registered and glitch-free.
- Counter: width idx_width(DrainTimeout+1); cleared on entering DRAIN; saturates, no wrap.

Decomposition:
- Package addr_map_cfg_pkg: cfg_op_e (WRITE, COMMIT, DISCARD, RSVD); state_e (IDLE, DRAIN, COMMIT).
- Sub-module addr_rule_check: combinational, parameterised like the controller. Inputs: slot, rule. Output: ok. It is reused by bench scoreboards.

Test Plan:
- WRITE slot 0 with {idx 1, start 'h1000, end 'h2000}, then COMMIT with quiesce_ack_i tied to 1 -> write response error 0; COMMIT takes 3 cycles from accept to response; config_ongoing_o high exactly 1 cycle; addr_map_o[0] updated in the response cycle.
- WRITE {idx NoIndices, …}, then {start 'h3000, end 'h2000}, then slot NoRules -> three responses, each error 1; dirty_o stays 0.
- WRITE valid rule, COMMIT, hold quiesce_ack_i = 0 with DrainTimeout = 8 -> error response 8 cycles after DRAIN entry; addr_map_o unchanged; dirty_o = 1. Retry with ack -> success.
- WRITE, then DISCARD, then COMMIT -> all errors 0; no quiesce_req_o pulse; addr_map_o still DefaultMap.
- Assert rst_i during the COMMIT cycle -> next cycle addr_map_o = DefaultMap, no response, config_ongoing_o = 0.
- Four back-to-back WRITEs to slots 0..3 -> four consecutive response pulses; ready never drops in IDLE.
